// File: rtl/ex_mem_forward.sv
// EX/MEM pipeline register with forwarding-select unit and load-use stall FSM.
// Latency: EX/MEM state is captured one edge after EX; the forward selects and the stall request are combinational from state and inputs.
// Backpressure: hold freezes every register and masks the stall request; flush turns the captured EX instruction into a bubble.
module ex_mem_forward #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] ex_alu,
    input  logic [NBITS-1:0] ex_wrd,
    input  logic [4:0]       ex_addr_dest,
    input  logic [3:0]       ex_ctl,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             hold,
    input  logic             flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [NBITS-1:0] ex_mem_ALU,
    output logic [NBITS-1:0] mem_wrd,
    output logic [4:0]       mem_addr_dest,
    output logic [3:0]       mem_ctl,
    output logic             load_use_stall,
    output logic [15:0]      stall_count
);

    // Control flag positions within ex_ctl / mem_ctl: {valid, regwrite, memread, memwrite}.
    localparam int CTL_VALID = 3;
    localparam int CTL_RW    = 2;
    localparam int CTL_MR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] wb_dest;
    logic       wb_regwrite;
    logic       wb_valid;
    logic       mem_fwd_ok;
    logic       wb_fwd_ok;
    logic       load_hit;

    // EX/MEM register: capture the EX instruction, bubbling its control on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_ALU    <= '0;
            mem_wrd       <= '0;
            mem_addr_dest <= '0;
            mem_ctl       <= '0;
        end else if (!hold) begin
            ex_mem_ALU    <= ex_alu;
            mem_wrd       <= ex_wrd;
            mem_addr_dest <= ex_addr_dest;
            mem_ctl       <= flush ? 4'b0000 : ex_ctl;
        end
    end

    // MEM/WB tracking: only what the forwarding unit needs to recognise a WB-stage writer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_dest     <= '0;
            wb_regwrite <= 1'b0;
            wb_valid    <= 1'b0;
        end else if (!hold) begin
            wb_dest     <= mem_addr_dest;
            wb_regwrite <= mem_ctl[CTL_RW];
            wb_valid    <= mem_ctl[CTL_VALID];
        end
    end

    // A load in MEM has no data yet, so it never qualifies as an EX/MEM source; $0 is never forwarded.
    assign mem_fwd_ok = mem_ctl[CTL_VALID] & mem_ctl[CTL_RW] & ~mem_ctl[CTL_MR]
                      & (mem_addr_dest != 5'd0);
    assign wb_fwd_ok  = wb_valid & wb_regwrite & (wb_dest != 5'd0);

    // Operand selects: the younger EX/MEM result wins over the older WB result.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (mem_fwd_ok && (mem_addr_dest == idex_rs)) begin
            forwardA = 2'b10;
        end else if (wb_fwd_ok && (wb_dest == idex_rs)) begin
            forwardA = 2'b01;
        end
        if (mem_fwd_ok && (mem_addr_dest == idex_rt)) begin
            forwardB = 2'b10;
        end else if (wb_fwd_ok && (wb_dest == idex_rt)) begin
            forwardB = 2'b01;
        end
    end

    // A load in EX whose destination feeds the instruction in ID.
    assign load_hit = ex_ctl[CTL_VALID] & ex_ctl[CTL_MR] & ex_ctl[CTL_RW]
                    & (ex_addr_dest != 5'd0)
                    & ((ex_addr_dest == ifid_rs) | (ex_addr_dest == ifid_rt));

    // Stall FSM next state and request; STALL lasts one unheld cycle so a load cannot re-trigger.
    always_comb begin
        state_nxt      = state;
        load_use_stall = 1'b0;
        case (state)
            IDLE: begin
                if (reset && !hold && load_hit) begin
                    load_use_stall = 1'b1;
                    state_nxt      = STALL;
                end
            end
            STALL: begin
                if (!hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stall FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating count of IDLE->STALL transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (load_use_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ex_mem_forward.sv
// Randomised and directed bench for ex_mem_forward against a pipeline-history model.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after the rising edge.
// The model tracks the instruction held in MEM and in WB, plus whether the last cycle stalled.
module tb_ex_mem_forward;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] ex_alu, ex_wrd;
    logic [4:0]    ex_addr_dest;
    logic [3:0]    ex_ctl;
    logic [4:0]    idex_rs, idex_rt, ifid_rs, ifid_rt;
    logic          hold, flush;
    logic [1:0]    forwardA, forwardB;
    logic [NB-1:0] ex_mem_ALU, mem_wrd;
    logic [4:0]    mem_addr_dest;
    logic [3:0]    mem_ctl;
    logic          load_use_stall;
    logic [15:0]   stall_count;

    always #5 clk = ~clk;

    ex_mem_forward #(.NBITS(NB)) dut (
        .clk(clk), .reset(reset),
        .ex_alu(ex_alu), .ex_wrd(ex_wrd), .ex_addr_dest(ex_addr_dest), .ex_ctl(ex_ctl),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .hold(hold), .flush(flush),
        .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_ALU(ex_mem_ALU), .mem_wrd(mem_wrd), .mem_addr_dest(mem_addr_dest),
        .mem_ctl(mem_ctl), .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    // One instruction as it sits in a pipeline stage.
    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] wrd;
    } rec_t;

    rec_t m_mem, m_wb;
    bit   m_win;      // previous cycle issued a stall, so the same load must not stall again
    int   m_cnt;
    int   errors = 0;
    int   checks = 0;

    task automatic model_clear();
        m_mem = '0;
        m_wb  = '0;
        m_win = 1'b0;
        m_cnt = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (m_mem.v && m_mem.rw && !m_mem.mr && m_mem.dest != 0 && m_mem.dest == src) return 2'b10;
        if (m_wb.v && m_wb.rw && m_wb.dest != 0 && m_wb.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        if (!reset || hold || m_win) return 1'b0;
        return ex_ctl[3] && ex_ctl[2] && ex_ctl[1] && ex_addr_dest != 0 &&
               (ex_addr_dest == ifid_rs || ex_addr_dest == ifid_rt);
    endfunction

    // Advance one rising edge and move instructions through the model.
    task automatic tick();
        logic st;
        st = exp_stall();
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else if (!hold) begin
            m_wb      = m_mem;
            m_mem.v   = flush ? 1'b0 : ex_ctl[3];
            m_mem.rw  = flush ? 1'b0 : ex_ctl[2];
            m_mem.mr  = flush ? 1'b0 : ex_ctl[1];
            m_mem.mw  = flush ? 1'b0 : ex_ctl[0];
            m_mem.dest = ex_addr_dest;
            m_mem.alu  = ex_alu;
            m_mem.wrd  = ex_wrd;
            if (st && m_cnt < 65535) m_cnt++;
            m_win = st;
        end
        #1;
    endtask

    task automatic set_ex(input logic [3:0] ctl, input logic [4:0] dest, input logic [31:0] alu);
        ex_ctl       = ctl;
        ex_addr_dest = dest;
        ex_alu       = alu;
        ex_wrd       = ~alu;
    endtask

    task automatic test_reset();
        set_ex(4'b1110, 5'd5, 32'hDEAD);
        ifid_rs = 5'd5;
        #2;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", load_use_stall); end
        checks++; if (forwardA !== 2'b00 || forwardB !== 2'b00) begin errors++; $display("FAIL rst_fwd got=%b/%b exp=00/00", forwardA, forwardB); end
        checks++; if (mem_ctl !== 4'h0 || ex_mem_ALU !== '0 || mem_wrd !== '0 || mem_addr_dest !== 5'd0) begin
            errors++; $display("FAIL rst_exmem got ctl=%h alu=%h wrd=%h dest=%0d exp all 0", mem_ctl, ex_mem_ALU, mem_wrd, mem_addr_dest); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", stall_count); end
        set_ex(4'b0000, 5'd0, 32'h0);
        ifid_rs = 5'd0;
        reset = 1'b1;
        #1;
        checks++; if (forwardA !== 2'b00 || forwardB !== 2'b00 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL post_rst got=%b/%b/%b exp=00/00/0", forwardA, forwardB, load_use_stall); end
    endtask

    task automatic test_ex_fwd();
        set_ex(4'b1100, 5'd3, 32'h10);
        tick();
        set_ex(4'b1100, 5'd4, 32'h20);
        idex_rs = 5'd3;
        #2;
        checks++; if (forwardA !== 2'b10) begin errors++; $display("FAIL exmem_fwdA got=%b exp=10", forwardA); end
        checks++; if (ex_mem_ALU !== 32'h10) begin errors++; $display("FAIL exmem_alu got=%h exp=10", ex_mem_ALU); end
        checks++; if (forwardB !== 2'b00) begin errors++; $display("FAIL exmem_fwdB got=%b exp=00", forwardB); end
    endtask

    task automatic test_wb_fwd();
        idex_rs = 5'd0;
        set_ex(4'b1100, 5'd3, 32'h33);
        tick();
        set_ex(4'b0000, 5'd0, 32'h0);
        tick();
        idex_rt = 5'd3;
        #2;
        checks++; if (forwardB !== 2'b01) begin errors++; $display("FAIL wb_fwdB got=%b exp=01", forwardB); end
        set_ex(4'b1100, 5'd3, 32'h44);
        tick();
        set_ex(4'b1100, 5'd3, 32'h55);
        tick();
        set_ex(4'b0000, 5'd0, 32'h0);
        #2;
        checks++; if (forwardB !== 2'b10) begin errors++; $display("FAIL both_fwdB got=%b exp=10", forwardB); end
        checks++; if (ex_mem_ALU !== 32'h55) begin errors++; $display("FAIL both_alu got=%h exp=55", ex_mem_ALU); end
        idex_rt = 5'd0;
    endtask

    task automatic test_load_use();
        set_ex(4'b1110, 5'd5, 32'h500);
        ifid_rs = 5'd5;
        #2;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", load_use_stall); end
        tick();
        // same load still presented while the pipeline bubbles it out
        flush = 1'b1;
        #2;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_retrigger got=%b exp=0", load_use_stall); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        tick();
        flush = 1'b0;
        ifid_rs = 5'd0;
        set_ex(4'b1100, 5'd6, 32'h600);
        idex_rs = 5'd5;
        #2;
        checks++; if (forwardA !== 2'b01) begin errors++; $display("FAIL lu_fwdA got=%b exp=01", forwardA); end
        checks++; if (load_use_stall !== 1'b0 || stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_after got stall=%b cnt=%0d exp 0/1", load_use_stall, stall_count); end
    endtask

    task automatic test_zero_reg();
        idex_rs = 5'd0;
        for (int i = 0; i < 3; i++) begin
            set_ex(4'b1100, 5'd0, 32'hF0 + i);
            tick();
            #2;
            checks++; if (forwardA !== 2'b00) begin errors++; $display("FAIL zero_fwdA cycle=%0d got=%b exp=00", i, forwardA); end
        end
        set_ex(4'b1110, 5'd0, 32'h0);
        ifid_rs = 5'd0;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", load_use_stall); end
    endtask

    task automatic test_hold();
        set_ex(4'b1100, 5'd7, 32'h77);
        tick();
        hold = 1'b1;
        flush = 1'b1;
        idex_rs = 5'd7;
        ifid_rs = 5'd8;
        for (int i = 0; i < 3; i++) begin
            set_ex(4'b1110, 5'd8, $urandom);
            #2;
            checks++; if (forwardA !== 2'b10 || ex_mem_ALU !== 32'h77 || mem_ctl !== 4'b1100) begin
                errors++; $display("FAIL hold_state cycle=%0d got fwd=%b alu=%h ctl=%h exp 10/77/c", i, forwardA, ex_mem_ALU, mem_ctl); end
            checks++; if (load_use_stall !== 1'b0 || stall_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL hold_stall cycle=%0d got stall=%b cnt=%0d exp 0/%0d", i, load_use_stall, stall_count, m_cnt); end
            tick();
        end
        hold = 1'b0;
        flush = 1'b0;
        set_ex(4'b1110, 5'd8, 32'h88);
        #2;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", load_use_stall); end
        tick();
        idex_rs = 5'd0;
    endtask

    task automatic test_reset_mid_stall();
        idex_rt = 5'd7;
        #2;
        checks++; if (forwardB !== 2'b01 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL prerst got fwdB=%b stall=%b exp 01/0", forwardB, load_use_stall); end
        reset = 1'b0;
        #1;
        model_clear();
        checks++; if (forwardA !== 2'b00 || forwardB !== 2'b00 || load_use_stall !== 1'b0 || mem_ctl !== 4'h0 ||
                      ex_mem_ALU !== '0 || mem_wrd !== '0 || mem_addr_dest !== 5'd0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL midrst got fA=%b fB=%b st=%b ctl=%h alu=%h cnt=%0d exp all 0",
                               forwardA, forwardB, load_use_stall, mem_ctl, ex_mem_ALU, stall_count); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (load_use_stall !== 1'b1 || forwardB !== 2'b00) begin
            errors++; $display("FAIL rst_fresh got stall=%b fwdB=%b exp 1/00", load_use_stall, forwardB); end
        tick();
        #2;
        checks++; if (stall_count !== 16'd1 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL rst_fresh_cnt got cnt=%0d stall=%b exp 1/0", stall_count, load_use_stall); end
        idex_rt = 5'd0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            hold         = ($urandom_range(7) == 0);
            flush        = ($urandom_range(7) == 0);
            ex_ctl       = 4'($urandom_range(15));
            ex_addr_dest = 5'($urandom_range(3));
            ex_alu       = $urandom;
            ex_wrd       = $urandom;
            idex_rs      = 5'($urandom_range(3));
            idex_rt      = 5'($urandom_range(3));
            ifid_rs      = 5'($urandom_range(3));
            ifid_rt      = 5'($urandom_range(3));
            #2;
            checks++; if (forwardA !== exp_fwd(idex_rs) || forwardB !== exp_fwd(idex_rt)) begin
                errors++; $display("FAIL rnd_fwd i=%0d got=%b/%b exp=%b/%b", i, forwardA, forwardB, exp_fwd(idex_rs), exp_fwd(idex_rt)); end
            checks++; if (load_use_stall !== exp_stall()) begin
                errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, load_use_stall, exp_stall()); end
            checks++; if (mem_ctl !== {m_mem.v, m_mem.rw, m_mem.mr, m_mem.mw} || ex_mem_ALU !== m_mem.alu ||
                          mem_wrd !== m_mem.wrd || mem_addr_dest !== m_mem.dest) begin
                errors++; $display("FAIL rnd_exmem i=%0d got ctl=%h alu=%h wrd=%h dest=%0d exp ctl=%h alu=%h wrd=%h dest=%0d", i,
                                   mem_ctl, ex_mem_ALU, mem_wrd, mem_addr_dest,
                                   {m_mem.v, m_mem.rw, m_mem.mr, m_mem.mw}, m_mem.alu, m_mem.wrd, m_mem.dest); end
            checks++; if (stall_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, stall_count, m_cnt); end
            tick();
        end
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        idex_rs = '0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        set_ex(4'b0000, 5'd0, 32'h0);
        model_clear();
        test_reset();
        test_ex_fwd();
        test_wb_fwd();
        test_load_use();
        test_zero_reg();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_forward.md
EX_MEM_FORWARD -- requirements
Module: ex_mem_forward

Interface
REQ-001 SHALL have parameter NBITS, default 32, datapath width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_alu / ex_wrd  in  NBITS each  ALU result and store data from EX.
REQ-005 SHALL have port ex_addr_dest  in  5  destination register from EX.
REQ-006 SHALL have port ex_ctl  in  4  control flags {valid, regwrite, memread, memwrite} of the EX instruction.
REQ-007 SHALL have port idex_rs / idex_rt  in  5 each  source registers of the instruction currently in EX.
REQ-008 SHALL have port ifid_rs / ifid_rt  in  5 each  source registers of the instruction currently in ID.
REQ-009 SHALL have port hold  in  1  memory busy; freezes all pipeline state.
REQ-010 SHALL have port flush  in  1  turns the EX instruction into a bubble at capture.
REQ-011 SHALL have port forwardA / forwardB  out  2 each  EX operand select: 00 = register file, 01 = WB value, 10 = EX/MEM ALU value.
REQ-012 SHALL have port ex_mem_ALU / mem_wrd  out  NBITS each  registered EX/MEM ALU result and store data.
REQ-013 SHALL have port mem_addr_dest  out  5  registered EX/MEM destination register.
REQ-014 SHALL have port mem_ctl  out  4  registered EX/MEM {valid, regwrite, memread, memwrite}.
REQ-015 SHALL have port load_use_stall  out  1  stall request to PC/IF/ID and bubble request to ID/EX.
REQ-016 SHALL have port stall_count  out  16  count of load-use stalls taken.

Function
REQ-017 On each edge with hold=0, the EX/MEM registers SHALL capture ex_alu, ex_wrd, ex_addr_dest and ex_ctl.
REQ-018 With flush=1 and hold=0, the EX/MEM registers SHALL capture ex_ctl=0, so valid, regwrite, memread and memwrite are all 0.
REQ-019 The MEM/WB tracking registers (wb_dest, wb_regwrite, wb_valid) SHALL capture the EX/MEM values on each edge with hold=0.
REQ-020 With hold=1, all registers SHALL retain their values; hold SHALL take priority over flush.
REQ-021 The EX/MEM hit condition SHALL be: mem valid & regwrite & !memread & mem_addr_dest!=0 & mem_addr_dest==src.
REQ-022 The WB hit condition SHALL be: wb_valid & wb_regwrite & wb_dest!=0 & wb_dest==src.
REQ-023 forwardA (src=idex_rs) and forwardB (src=idex_rt) SHALL be combinational from the registered state: 10 on an EX/MEM hit, else 01 on a WB hit, else 00; the value 11 SHALL never be driven.
REQ-024 Forwarding latency SHALL be zero cycles: a result produced in cycle N SHALL be selectable by the dependent instruction in EX in cycle N+1 (via EX/MEM) and N+2 (via WB).
REQ-025 The load-use stall FSM SHALL have two states, IDLE and STALL.
REQ-026 In IDLE, if ex_ctl valid & memread & regwrite & ex_addr_dest!=0 & ex_addr_dest is in {ifid_rs, ifid_rt}, and hold=0, the FSM SHALL assert load_use_stall combinationally and go to STALL at the edge.
REQ-027 In STALL, load_use_stall SHALL be 0 and the FSM SHALL return to IDLE on the next edge with hold=0.
REQ-028 The stall SHALL last exactly one cycle per load, and the FSM SHALL never re-trigger on the same load.
REQ-029 With hold=1, the FSM state SHALL be frozen and load_use_stall SHALL be 0.
REQ-030 stall_count SHALL increment on each IDLE->STALL transition and saturate at 0xFFFF.
REQ-031 The module SHALL consume no clock-domain crossings and SHALL implement no combinational path from ex_alu to forwardA/forwardB.

Reset
REQ-032 While reset=0, all registers SHALL asynchronously clear to 0: mem_ctl=0, ex_mem_ALU=0, mem_wrd=0, mem_addr_dest=0, wb_* = 0, FSM = IDLE, stall_count=0.
REQ-033 During and immediately after reset: forwardA=forwardB=00 and load_use_stall=0.
REQ-034 Reset asserted mid-stall SHALL return the FSM to IDLE and discard all in-flight instructions.

Verification
REQ-035 add $3 (ALU=0x10) then dependent sub with idex_rs=3 next cycle -> forwardA=10, ex_mem_ALU=0x10.
REQ-036 $3 writer followed two cycles later by a use with idex_rt=3, and no intervening writer -> forwardB=01; with $3 in both EX/MEM and WB -> forwardB=10.
REQ-037 lw $5 in EX, ifid_rs=5 -> load_use_stall=1 for exactly one cycle, stall_count=1; next cycle with idex_rs=5 -> forwardA=01.
REQ-038 Writer to $0 with idex_rs=0 -> forwardA=00 in all cycles.
REQ-039 hold=1 for 3 cycles with a pending forward -> forwardA and EX/MEM outputs are stable, and no stall is counted.
REQ-040 reset=0 asserted mid-STALL -> all outputs are 0 within the same cycle; after release, the first load-use triggers a fresh one-cycle stall.
